// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer.
// Provides the FSM state encoding exported on the timer's state port.
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/countdown_prescaler.sv
// Clock prescaler for the countdown timer: emits one tick every PRESCALE
// enabled cycles.
// Ports:
//   clock   - system clock
//   reset_n - asynchronous active-low reset
//   enable  - advance the prescaler this cycle (holds when low)
//   clear   - restart the prescaler from zero
//   tick    - high on the enabled cycle where the prescaler wraps
module countdown_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned PS_W = $clog2(PRESCALE) + 1;
   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps;

   // Prescaler phase counter, wraps at PRESCALE-1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ps <= '0;
      end else if (clear) begin
         ps <= '0;
      end else if (enable) begin
         ps <= (ps == LAST) ? '0 : ps + PS_W'(1);
      end
   end

   assign tick = enable && !clear && (ps == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Pausable countdown timer with one-shot and auto-reload modes.
// Optional feature macro: COUNTDOWN_ELAPSED_EN adds the elapsed RUN-cycle counter.
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset
//   start_value     - value captured by load
//   load            - capture start_value (IDLE/DONE only)
//   go              - start/restart counting (IDLE/DONE only)
//   pause           - level, hold the count while high
//   abort           - return to IDLE, restoring the reload value
//   auto_reload     - level, restart from the reload value on expiry
//   count           - current counter value
//   state           - IDLE=0, RUN=1, PAUSE=2, DONE=3
//   busy            - high in RUN or PAUSE
//   done            - high in DONE
//   done_pulse      - one cycle per expiry
//   elapsed         - (macro only) cycles spent in RUN since last go/load/abort
module countdown_timer
   import countdown_pkg::*;
#(
   parameter  int unsigned WIDTH    = 9,
   parameter  int unsigned PRESCALE = 1,
   localparam int unsigned PS_W     = $clog2(PRESCALE) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] start_value,
   input  logic             load,
   input  logic             go,
   input  logic             pause,
   input  logic             abort,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             busy,
   output logic             done,
`ifdef COUNTDOWN_ELAPSED_EN
   output logic             done_pulse,
   output logic [WIDTH+PS_W-1:0] elapsed
`else
   output logic             done_pulse
`endif
);

   state_t           st_q, st_d;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] base;
   logic             pulse_d;
   logic             idle_or_done;
   logic             active;
   logic             ps_en;
   logic             ps_clear;
   logic             tick;

   assign idle_or_done = (st_q == ST_IDLE) || (st_q == ST_DONE);
   assign active       = (st_q == ST_RUN) || (st_q == ST_PAUSE);

   // The resume edge out of PAUSE also advances the prescaler, so a pause
   // costs exactly the number of cycles it is held.
   assign ps_en    = active && !pause && !abort;
   assign ps_clear = abort || (go && !load && idle_or_done);

   countdown_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (ps_en),
      .clear   (ps_clear),
      .tick    (tick)
   );

   // Next-state and counter logic, priority abort > load > go > pause > tick.
   always_comb begin
      st_d     = st_q;
      count_d  = count;
      reload_d = reload_q;
      pulse_d  = 1'b0;
      base     = (st_q == ST_DONE) ? reload_q : count;
      if (abort) begin
         st_d    = ST_IDLE;
         count_d = reload_q;
      end else if (load && idle_or_done) begin
         st_d     = ST_IDLE;
         reload_d = start_value;
         count_d  = start_value;
      end else if (go && idle_or_done) begin
         count_d = base;
         if (base == '0) begin
            st_d    = ST_DONE;
            pulse_d = 1'b1;
         end else begin
            st_d = ST_RUN;
         end
      end else if (active) begin
         if (pause) begin
            st_d = ST_PAUSE;
         end else begin
            st_d = ST_RUN;
            if (tick) begin
               if (count > WIDTH'(1)) begin
                  count_d = count - WIDTH'(1);
               end else begin
                  pulse_d = 1'b1;
                  if (auto_reload && (reload_q != '0)) begin
                     count_d = reload_q;
                  end else begin
                     count_d = '0;
                     st_d    = ST_DONE;
                  end
               end
            end
         end
      end
   end

   // State, counter and registered status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         st_q       <= ST_IDLE;
         count      <= '0;
         reload_q   <= '0;
         done_pulse <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         st_q       <= st_d;
         count      <= count_d;
         reload_q   <= reload_d;
         done_pulse <= pulse_d;
         busy       <= (st_d == ST_RUN) || (st_d == ST_PAUSE);
         done       <= (st_d == ST_DONE);
      end
   end

   assign state = st_q;

`ifdef COUNTDOWN_ELAPSED_EN
   logic clr_el;
   assign clr_el = abort || (idle_or_done && (load || go));

   // Saturating count of cycles spent in RUN.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         elapsed <= '0;
      end else if (clr_el) begin
         elapsed <= '0;
      end else if ((st_q == ST_RUN) && (elapsed != '1)) begin
         elapsed <= elapsed + (WIDTH+PS_W)'(1);
      end
   end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) share stimulus and are
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] sv;
   logic       ld, g, pz, ab, ar;

   logic [8:0] c1, c4;
   logic [1:0] s1, s4;
   logic       b1, b4, d1, d4, p1, p4;
`ifdef COUNTDOWN_ELAPSED_EN
   logic [9:0]  e1;
   logic [11:0] e4;
`endif

   int n_checks = 0;
   int n_err    = 0;

   int ps_of[2] = '{1, 4};
   int m_st[2], m_cnt[2], m_rel[2], m_ps[2], m_pulse[2], m_el[2];

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(9), .PRESCALE(1)) dut1 (
      .clock(clk), .reset_n(rst_n), .start_value(sv), .load(ld), .go(g),
      .pause(pz), .abort(ab), .auto_reload(ar), .count(c1), .state(s1),
      .busy(b1), .done(d1),
`ifdef COUNTDOWN_ELAPSED_EN
      .elapsed(e1),
`endif
      .done_pulse(p1));

   countdown_timer #(.WIDTH(9), .PRESCALE(4)) dut4 (
      .clock(clk), .reset_n(rst_n), .start_value(sv), .load(ld), .go(g),
      .pause(pz), .abort(ab), .auto_reload(ar), .count(c4), .state(s4),
      .busy(b4), .done(d4),
`ifdef COUNTDOWN_ELAPSED_EN
      .elapsed(e4),
`endif
      .done_pulse(p4));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_cnt[i] = 0; m_rel[i] = 0; m_ps[i] = 0; m_pulse[i] = 0; m_el[i] = 0;
      end
   endtask

   // One clock edge of the timer behaviour, applied to the current inputs.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int  st0 = m_st[i];
         bit  parked = (st0 == 0) || (st0 == 3);
         bit  clr = ab || (parked && (ld || g));
         int  el_max = (i == 0) ? 1023 : 4095;
         m_pulse[i] = 0;
         if (ab) begin
            m_st[i] = 0; m_cnt[i] = m_rel[i]; m_ps[i] = 0;
         end else if (ld && parked) begin
            m_rel[i] = int'(sv); m_cnt[i] = int'(sv); m_st[i] = 0;
         end else if (g && parked) begin
            if (st0 == 3) m_cnt[i] = m_rel[i];
            if (m_cnt[i] == 0) begin
               m_st[i] = 3; m_pulse[i] = 1;
            end else begin
               m_st[i] = 1; m_ps[i] = 0;
            end
         end else if (!parked) begin
            if (pz) begin
               m_st[i] = 2;
            end else begin
               m_st[i] = 1;
               m_ps[i] = m_ps[i] + 1;
               if (m_ps[i] == ps_of[i]) begin
                  m_ps[i] = 0;
                  if (m_cnt[i] > 1) begin
                     m_cnt[i]--;
                  end else begin
                     m_pulse[i] = 1;
                     if (ar && m_rel[i] != 0) m_cnt[i] = m_rel[i];
                     else begin m_cnt[i] = 0; m_st[i] = 3; end
                  end
               end
            end
         end
         if (clr) m_el[i] = 0;
         else if (st0 == 1 && m_el[i] < el_max) m_el[i]++;
      end
   endtask

   task automatic check_dut(input int i, input logic [8:0] c, input logic [1:0] s,
                            input logic b, input logic d, input logic p);
      string pfx = (i == 0) ? "p1" : "p4";
      check({pfx, " count"}, 32'(c), m_cnt[i]);
      check({pfx, " state"}, 32'(s), m_st[i]);
      check({pfx, " busy"}, 32'(b), (m_st[i] == 1 || m_st[i] == 2) ? 1 : 0);
      check({pfx, " done"}, 32'(d), (m_st[i] == 3) ? 1 : 0);
      check({pfx, " done_pulse"}, 32'(p), m_pulse[i]);
   endtask

   task automatic compare_all();
      check_dut(0, c1, s1, b1, d1, p1);
      check_dut(1, c4, s4, b4, d4, p4);
`ifdef COUNTDOWN_ELAPSED_EN
      check("p1 elapsed", 32'(e1), m_el[0]);
      check("p4 elapsed", 32'(e4), m_el[1]);
`endif
   endtask

   // Drive inputs just after a falling edge, advance the model, compare at the next one.
   task automatic cycle(input logic l, input logic gg, input logic p, input logic a,
                        input logic r, input logic [8:0] v);
      ld = l; g = gg; pz = p; ab = a; ar = r; sv = v;
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ld = 0; g = 0; pz = 0; ab = 0; ar = 0; sv = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      compare_all();
      check("reset count", 32'(c1), 0);
      check("reset state", 32'(s4), 0);

      // load 5, go: count 4..0 then a single done pulse
      cycle(1, 0, 0, 0, 0, 9'd5);
      cycle(0, 1, 0, 0, 0, 9'd0);
      for (int j = 1; j <= 5; j++) begin
         cycle(0, 0, 0, 0, 0, 9'd0);
         check("d1 count", 32'(c1), 32'(5 - j));
         check("d1 pulse", 32'(p1), (j == 5) ? 1 : 0);
      end
      check("d1 done", 32'(d1), 1);
      check("d1 state", 32'(s1), 3);
      cycle(0, 0, 0, 0, 0, 9'd0);
      check("d1 pulse once", 32'(p1), 0);

      // load 0, go: immediate DONE
      cycle(0, 0, 0, 1, 0, 9'd0);
      cycle(1, 0, 0, 0, 0, 9'd0);
      cycle(0, 1, 0, 0, 0, 9'd0);
      check("zero done", 32'(s1), 3);
      check("zero pulse", 32'(p4), 1);
      check("zero count", 32'(c4), 0);

      // PRESCALE 4, load 3, six paused cycles: done lands at k+18
      cycle(0, 0, 0, 1, 0, 9'd0);
      cycle(1, 0, 0, 0, 0, 9'd3);
      cycle(0, 1, 0, 0, 0, 9'd0);
      for (int j = 1; j <= 18; j++) begin
         cycle(0, 0, (j >= 6 && j <= 11), 0, 0, 9'd0);
         if (j >= 7 && j <= 11) begin
            check("pause state", 32'(s4), 2);
            check("pause count", 32'(c4), 2);
         end
         if (j == 17) check("ps4 not yet done", 32'(d4), 0);
      end
      check("ps4 done k+18", 32'(d4), 1);
      check("ps4 pulse k+18", 32'(p4), 1);

      // auto-reload: pulses at k+2,k+4,k+6, then one-shot expiry
      cycle(0, 0, 0, 1, 1, 9'd0);
      cycle(1, 0, 0, 0, 1, 9'd2);
      cycle(0, 1, 0, 0, 1, 9'd0);
      for (int j = 1; j <= 6; j++) begin
         cycle(0, 0, 0, 0, 1, 9'd0);
         check("ar pulse", 32'(p1), (j % 2 == 0) ? 1 : 0);
         check("ar done low", 32'(d1), 0);
      end
      cycle(0, 0, 0, 0, 0, 9'd0);
      cycle(0, 0, 0, 0, 0, 9'd0);
      check("ar off done", 32'(d1), 1);

      // load ignored in RUN, abort restores reload value
      cycle(1, 0, 0, 0, 0, 9'd7);
      cycle(0, 1, 0, 0, 0, 9'd0);
      cycle(1, 0, 0, 0, 0, 9'd2);
      check("run load ignored", 32'(c1), 6);
      cycle(0, 0, 0, 0, 0, 9'd0);
      cycle(0, 0, 0, 0, 0, 9'd0);
      check("pre-abort count", 32'(c1), 4);
      cycle(0, 0, 0, 1, 0, 9'd0);
      check("abort state", 32'(s1), 0);
      check("abort count", 32'(c1), 7);
      check("abort done", 32'(d1), 0);

      // asynchronous reset mid-RUN
      cycle(1, 0, 0, 0, 0, 9'd5);
      cycle(0, 1, 0, 0, 0, 9'd0);
      cycle(0, 0, 0, 0, 0, 9'd0);
      cycle(0, 0, 0, 0, 0, 9'd0);
      check("pre-reset count", 32'(c1), 3);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 1, 0, 0, 0, 9'd0);
      check("post-reset go done", 32'(s1), 3);
      check("post-reset go pulse", 32'(p1), 1);

      // randomized traffic
      pz = 0; ar = 0;
      for (int n = 0; n < 3000; n++) begin
         logic       rl, rg, ra, rp, rr;
         logic [8:0] rv;
         ra = ($urandom_range(0, 99) < 3);
         rl = ($urandom_range(0, 9) == 0);
         rg = ($urandom_range(0, 7) == 0);
         rp = pz;
         rr = ar;
         if ($urandom_range(0, 15) == 0) rp = !rp;
         if ($urandom_range(0, 63) == 0) rr = !rr;
         if ($urandom_range(0, 7) == 0) rv = 9'($urandom_range(0, 511));
         else rv = 9'($urandom_range(0, 6));
         cycle(rl, rg, rp, ra, rr, rv);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
